// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch initiator.
// Optional range checking is enabled by defining IFETCH_RANGE_CHECK_EN.
package ifetch_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

`ifdef IFETCH_RANGE_CHECK_EN
  localparam int ENTRY_W = 65;  // {fault, pc, instr}
`else
  localparam int ENTRY_W = 64;  // {pc, instr}
`endif

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Skid FIFO between the RAM response port and decode.
// Flush beats push and pop; the head is zeroed while empty.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst && !flush)
      assert (!(push && count == CW'(DEPTH) && !do_pop))
        else $error("ifetch_fifo: push into full FIFO");
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Sequential instruction fetch with credit-based issue, skid FIFO and redirect flush.
// Define IFETCH_RANGE_CHECK_EN to tag out-of-range PCs and stall on them.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_request,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_valid,
  input  logic [31:0]       mem_read_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr
`ifdef IFETCH_RANGE_CHECK_EN
  ,
  output logic              if_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  state_e            state, state_nxt;
  logic [31:0]       fetch_pc, inflight_pc, rpc;
  logic              inflight, issue, pop, push, credit_ok, halt;
  logic [CW-1:0]     count;
  logic [CW:0]       used, limit;
  logic [ENTRY_W-1:0] wdata, head_data;

  assign rpc   = redirect_pc & ~32'h3;
  assign pop   = if_valid & if_ready;
  assign push  = mem_valid & inflight & ~redirect_valid;
  // A popped slot can be reissued in the same cycle, giving one fetch per clock at depth 2.
  assign used  = {1'b0, count} + (CW+1)'(inflight);
  assign limit = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign credit_ok = used < limit;

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    mem_address = fetch_pc[ADDR_W+1:2];
    case (state)
      IDLE: if (fetch_en) state_nxt = RUN;
      RUN: begin
        if (!fetch_en) state_nxt = IDLE;
        issue = fetch_en & (redirect_valid | (credit_ok & ~halt));
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) mem_address = rpc[ADDR_W+1:2];
  end

  assign mem_request = issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= redirect_valid ? rpc : fetch_pc;
      if (redirect_valid) fetch_pc <= issue ? rpc + PC_INC : rpc;
      else if (issue)     fetch_pc <= fetch_pc + PC_INC;
    end
  end

`ifdef IFETCH_RANGE_CHECK_EN
  logic entry_fault;
  assign entry_fault = |inflight_pc[31:ADDR_W+2];
  assign wdata = {entry_fault, inflight_pc, mem_read_data};
  assign {if_fault, if_pc, if_instr} = head_data;

  // Issue stays parked after a faulted push until software redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     halt <= 1'b0;
    else if (redirect_valid)      halt <= 1'b0;
    else if (push && entry_fault) halt <= 1'b1;
  end
`else
  assign halt  = 1'b0;
  assign wdata = {inflight_pc, mem_read_data};
  assign {if_pc, if_instr} = head_data;
`endif

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .wdata      (wdata),
    .count      (count),
    .head_valid (if_valid),
    .head_data  (head_data)
  );

  always_ff @(posedge clk) begin
    if (rst)
      assert (!(mem_valid && !inflight))
        else $warning("ifetch_ctrl: mem_valid with no outstanding request ignored");
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: queue-based reference model plus literal spot checks.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0, inject = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_request, mem_valid = 1'b0, if_valid;
  logic [7:0]  mem_address;
  logic [31:0] mem_read_data = '0, if_pc, if_instr;
`ifdef IFETCH_RANGE_CHECK_EN
  logic        if_fault;
`endif

  int checks = 0;
  int failures = 0;

  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_request(mem_request), .mem_address(mem_address),
    .mem_valid(mem_valid), .mem_read_data(mem_read_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
`ifdef IFETCH_RANGE_CHECK_EN
    , .if_fault(if_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // One-cycle-latency instruction RAM; inject forces a stray response.
  always @(posedge clk) begin
    mem_valid     <= mem_request | inject;
    mem_read_data <= ram_word(mem_address);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the decode side should see, kept as a plain queue.
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;
  ent_t        q[$];
  logic [31:0] m_fpc = 32'h0, m_ipc = 32'h0;
  logic        m_infl = 1'b0, m_run = 1'b0, m_halt = 1'b0;

  function automatic logic m_pop();
    return (q.size() != 0) && if_ready;
  endfunction

  function automatic logic m_issue();
    int used;
    used = q.size() + int'(m_infl) - int'(m_pop());
    return m_run && fetch_en && (redirect_valid || (used < 2 && !m_halt));
  endfunction

  logic        s_iss, s_pop;
  logic [31:0] s_rpc, s_ipc;
  ent_t        s_ent;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_fpc = 32'h0; m_ipc = 32'h0; m_infl = 1'b0; m_run = 1'b0; m_halt = 1'b0;
    end else begin
      s_iss = m_issue();
      s_pop = m_pop();
      s_rpc = {redirect_pc[31:2], 2'b00};
      if (redirect_valid) begin
        q.delete();
        m_halt = 1'b0;
        s_ipc  = s_rpc;
        m_fpc  = s_iss ? s_rpc + 32'd4 : s_rpc;
      end else begin
        if (s_pop) void'(q.pop_front());
        if (mem_valid && m_infl) begin
          s_ent.pc    = m_ipc;
          s_ent.instr = ram_word(m_ipc[9:2]);
`ifdef IFETCH_RANGE_CHECK_EN
          s_ent.fault = |m_ipc[31:10];
          if (s_ent.fault) m_halt = 1'b1;
`else
          s_ent.fault = 1'b0;
`endif
          q.push_back(s_ent);
        end
        s_ipc = m_fpc;
        if (s_iss) m_fpc = m_fpc + 32'd4;
      end
      if (s_iss) m_ipc = s_ipc;
      m_infl = s_iss;
      m_run  = fetch_en;
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    check("m_if_valid", {31'b0, if_valid}, {31'b0, q.size() != 0});
    check("m_if_pc", if_pc, (q.size() != 0) ? q[0].pc : 32'h0);
    check("m_if_instr", if_instr, (q.size() != 0) ? q[0].instr : 32'h0);
`ifdef IFETCH_RANGE_CHECK_EN
    check("m_if_fault", {31'b0, if_fault}, {31'b0, (q.size() != 0) ? q[0].fault : 1'b0});
`endif
    check("m_mem_request", {31'b0, mem_request}, {31'b0, m_issue()});
    check("m_mem_address", {24'b0, mem_address},
          {24'b0, redirect_valid ? redirect_pc[9:2] : m_fpc[9:2]});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    check("rst_mem_request", {31'b0, mem_request}, 32'h0);
    check("rst_mem_address", {24'b0, mem_address}, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Sequential stream from reset PC
    fetch_en = 1'b1; if_ready = 1'b1;
    tick();
    check("t1_req0", {31'b0, mem_request}, 32'h1);
    check("t1_addr0", {24'b0, mem_address}, 32'h0);
    tick();
    check("t1_addr1", {24'b0, mem_address}, 32'h1);
    tick();
    check("t1_first_valid", {31'b0, if_valid}, 32'h1);
    check("t1_first_pc", if_pc, 32'h0);
    check("t1_first_instr", if_instr, 32'hC300_FF5A);
    tick();
    check("t1_second_pc", if_pc, 32'h4);
    repeat (4) tick();

    // Backpressure
    if_ready = 1'b0;
    repeat (5) tick();
    check("t2_req_stalled", {31'b0, mem_request}, 32'h0);
    check("t2_head_held", if_pc, 32'h14);
    if_ready = 1'b1;
    tick();
    check("t2_resume_pc", if_pc, 32'h18);
    repeat (5) tick();

    // Redirect while the in-flight response would fill the FIFO
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    check("t3_redir_req", {31'b0, mem_request}, 32'h1);
    check("t3_redir_addr", {24'b0, mem_address}, 32'h10);
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed", {31'b0, if_valid}, 32'h0);
    if_ready = 1'b1;
    tick();
    check("t3_new_pc", if_pc, 32'h40);
    tick();
    check("t3_next_pc", if_pc, 32'h44);
    repeat (3) tick();

    // Redirect coinciding with push and pop (redirect_pc low bits ignored)
    redirect_valid = 1'b1; redirect_pc = 32'h83;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", {31'b0, if_valid}, 32'h0);
    tick();
    check("t4_new_pc", if_pc, 32'h80);
    tick();
    check("t4_next_pc", if_pc, 32'h84);
    repeat (2) tick();

    // Drain with fetch disabled, then redirect while idle
    fetch_en = 1'b0;
    repeat (4) tick();
    check("t4b_drained", {31'b0, if_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("t4b_idle_no_req", {31'b0, mem_request}, 32'h0);
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    tick();
    check("t4b_idle_redir_addr", {24'b0, mem_address}, 32'h40);
    repeat (3) tick();

    // Asynchronous reset mid-stream, stray response after release
    #1 rst = 1'b0;
    #1;
    check("t5_rst_req", {31'b0, mem_request}, 32'h0);
    check("t5_rst_addr", {24'b0, mem_address}, 32'h0);
    check("t5_rst_valid", {31'b0, if_valid}, 32'h0);
    check("t5_rst_pc", if_pc, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1; inject = 1'b1;
    tick();
    inject = 1'b0;
    check("t5_first_req", {31'b0, mem_request}, 32'h1);
    check("t5_first_addr", {24'b0, mem_address}, 32'h0);
    tick();
    check("t5_stray_ignored", {31'b0, if_valid}, 32'h0);
    tick();
    check("t5_first_valid", {31'b0, if_valid}, 32'h1);
    check("t5_first_pc", if_pc, 32'h0);
    repeat (2) tick();

`ifdef IFETCH_RANGE_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t6_fault_pc", if_pc, 32'h400);
    check("t6_fault_flag", {31'b0, if_fault}, 32'h1);
    check("t6_halted", {31'b0, mem_request}, 32'h0);
    repeat (3) tick();
    check("t6_still_halted", {31'b0, mem_request}, 32'h0);
    check("t6_drained", {31'b0, if_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t6_resume_pc", if_pc, 32'h0);
    check("t6_resume_fault", {31'b0, if_fault}, 32'h0);
    check("t6_resume_valid", {31'b0, if_valid}, 32'h1);
    repeat (2) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch initiator that drives the request side of the instruction RAM wrapper.
- RAM wrapper protocol: `request`/`address` in; `valid` + `read_data` returned exactly one cycle later.
- Generates sequential word fetches, absorbs fixed-latency responses into a small skid FIFO, and presents {pc, instr} to the decode stage with a valid/ready handshake.
- Handles redirects (branch/jump) by discarding the stale in-flight response and restarting at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- ADDR_W, 8: RAM word-address width; mem_address = fetch_pc[ADDR_W+1:2].
- FIFO_DEPTH, 2: skid FIFO entries. Must be >= 2 for full throughput.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  allow new requests; low = stop issuing. Buffered entries still drain.
- redirect_valid  in  1  one-cycle redirect strobe.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced to 0).
- mem_request  out  1  fetch request to RAM.
- mem_address  out  ADDR_W  word address of the request.
- mem_valid  in  1  response strobe, one cycle after mem_request.
- mem_read_data  in  32  instruction word; qualified by mem_valid.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode accepts head.
- if_pc  out  32  PC of head instruction.
- if_instr  out  32  head instruction.

Behaviour:
- Reset values (async, all outputs and state):
  - mem_request = 0, mem_address = RESET_PC[ADDR_W+1:2], if_valid = 0, if_pc = 0, if_instr = 0.
  - fetch_pc = RESET_PC, count = 0, inflight = 0, state = IDLE.
- FSM, 2 states:
  - IDLE: no requests. Go to RUN when fetch_en = 1.
  - RUN: issue per credit rule. Go to IDLE when fetch_en = 0; the current in-flight response is still captured.
- pop = if_valid & if_ready.
- Credit rule: issue = (state == RUN) & fetch_en & (count + inflight - pop < FIFO_DEPTH). mem_request = issue; it is combinational from if_ready.
- On issue:
  - inflight <= 1 and inflight_pc <= fetch_pc; otherwise inflight <= 0.
  - fetch_pc <= fetch_pc + 4, with 32-bit wrap.
- Response handling: when mem_valid = 1 and no redirect this cycle, push {inflight_pc, mem_read_data}.
  - The credit rule guarantees space. A push into a full FIFO without a pop is an assertion failure.
- Latency: request at cycle N, response at N+1, FIFO write at end of N+1, if_valid at N+2. There is no bypass.
- Steady state with if_ready = 1: one instruction per cycle.
- Simultaneous push and pop at any occupancy is legal; count is unchanged.
- Redirect takes priority over everything in its cycle:
  - FIFO is flushed: count <= 0, and if_valid drops the next cycle. No pop is counted.
  - The mem_valid response arriving this cycle is dropped.
  - If state == RUN and fetch_en = 1, a request is issued this same cycle at redirect_pc, and fetch_pc <= redirect_pc + 4. Otherwise fetch_pc <= redirect_pc.
  - First post-redirect if_valid occurs 2 cycles after the redirect, with if_pc = redirect_pc.
- Redirect in IDLE: updates fetch_pc only.
- fetch_en deasserted with entries buffered: entries drain normally; no new requests.
- mem_valid with inflight = 0: ignored; an assertion flags it.
- Reset mid-operation: everything returns to reset values immediately. A response arriving after reset release is ignored because inflight = 0.
- Address generation: mem_address = fetch_pc[ADDR_W+1:2], or redirect_pc[ADDR_W+1:2] in a redirect cycle. Upper PC bits are not forwarded.

Optional Feature:
- Macro: IFETCH_RANGE_CHECK_EN.
- When defined:
  - A 1-bit fault flag is stored per FIFO entry, plus output port if_fault (1 bit, reset 0).
  - An entry is faulted when its pc[31:ADDR_W+2] != 0; the request is still issued with truncated address.
  - if_fault is valid with if_valid.
  - Once a faulted entry is pushed, issuing stops until the next redirect.
- When undefined: no port, no per-entry fault storage, and out-of-range PCs silently alias.

Decomposition:
- Package ifetch_pkg holds:
  - the state enum {IDLE, RUN};
  - the FIFO entry width constant (64, or 65 with the feature);
  - the PC increment constant 4.
- Sub-module ifetch_fifo holds the skid FIFO: parameterized depth/width, push/pop/flush, count output, head outputs.

Test Plan:
1. Reset, then fetch_en = 1 at cycle 0, if_ready = 1:
   - mem_request = 1 at cycle 0 with mem_address = 0; cycle 1 address = 1; and so on.
   - if_valid at cycle 2 with if_pc = 0, then one instruction per cycle with if_pc = 4, 8, …
2. Backpressure: if_ready = 0 for 5 cycles mid-stream:
   - mem_request drops once count + inflight = 2.
   - No instruction is lost or duplicated; on release, the if_pc sequence stays contiguous.
3. Redirect with redirect_pc = 0x40 while a response is in flight and the FIFO is full:
   - Old response dropped, if_valid = 0 next cycle.
   - mem_address = 0x10 in the redirect cycle; next if_pc = 0x40, then 0x44.
4. Redirect coinciding with pop and push in the same cycle:
   - Flush wins; count = 0; no stale PC appears at the output.
5. rst asserted while inflight = 1 and count = 2:
   - All outputs return to reset values asynchronously.
   - After release with fetch_en = 1, the first fetch is at RESET_PC. A stray mem_valid is ignored.
6. With IFETCH_RANGE_CHECK_EN, redirect_pc = 0x400:
   - if_fault = 1 with if_pc = 0x400; issuing halts.
   - A redirect to 0x0 resumes with if_fault = 0.
